fmap_buffer_responder: RTL and testbench

//  On-chip feature-map buffer between two conv layers. Write side captures the

---
 rtl/fmap_buffer_responder_pkg.sv | 37 +++
 rtl/fmap_buffer_responder_if.sv | 25 ++
 rtl/fmap_sram_sp.sv | 27 ++
 rtl/fmap_buffer_responder.sv | 110 +++++++++++
 tb/tb_fmap_buffer_responder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fmap_buffer_responder_pkg.sv
// Shared constants, read-FSM encoding and helpers for the feature-map buffer.
package fmap_buffer_responder_pkg;

   localparam int WIDTH    = 32;
   localparam int HEIGHT   = 32;
   localparam int CHANNELS = 16;
   // One bit wider than the map needs, so pixel indices past the map can be requested and flagged.
   localparam int ADDR_W   = 11;
   localparam int CHAN_W   = 4;
   localparam int IN_W     = 32;
   localparam int DATA_W   = 16;

   localparam int NPIX   = WIDTH * HEIGHT;
   localparam int DEPTH  = CHANNELS * NPIX;
   localparam int MEM_AW = $clog2(DEPTH);
   localparam int PIX_AW = $clog2(NPIX);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACK,
      ST_DATA
   } rd_state_e;

   function automatic logic signed [DATA_W-1:0] sat16(input logic signed [IN_W-1:0] v);
      if (v > 32'sd32767)
         return 16'sh7fff;
      else if (v < -32'sd32768)
         return 16'sh8000;
      else
         return v[DATA_W-1:0];
   endfunction

   function automatic logic in_range(input int addr, input int chan);
      return (addr < NPIX) && (chan < CHANNELS);
   endfunction

endpackage

// File: rtl/fmap_buffer_responder_if.sv
// Producer write stream plus the consumer's addr/data valid-ready read port.
interface fmap_buffer_responder_if;
   import fmap_buffer_responder_pkg::*;

   logic                     wr_valid;
   logic signed [IN_W-1:0]   wr_data;
   logic [ADDR_W-1:0]        rd_addr;
   logic [CHAN_W-1:0]        rd_chan;
   logic                     rd_addr_valid;
   logic                     rd_addr_ready;
   logic signed [DATA_W-1:0] rd_data;
   logic                     rd_data_valid;
   logic                     rd_data_ready;

   modport master (
      output wr_valid, wr_data, rd_addr, rd_chan, rd_addr_valid, rd_data_ready,
      input  rd_addr_ready, rd_data, rd_data_valid
   );

   modport slave (
      input  wr_valid, wr_data, rd_addr, rd_chan, rd_addr_valid, rd_data_ready,
      output rd_addr_ready, rd_data, rd_data_valid
   );

endinterface

// File: rtl/fmap_sram_sp.sv
// Single-port synchronous-read SRAM with write enable, written to infer block RAM.
module fmap_sram_sp #(
   parameter int  DEPTH  = 1024,
   parameter int  DATA_W = 16,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: no reset on the array or q -- a reset here would stop BRAM inference; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we)
            mem[addr] <= wdata;
         else
            q <= mem[addr];
      end
   end

endmodule

// File: rtl/fmap_buffer_responder.sv
// Feature-map buffer: captures a producer stream, then serves single-word reads
// through a 3-state addr/data handshake once the buffer is full.
module fmap_buffer_responder
   import fmap_buffer_responder_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   output logic                    full,
   output logic                    overflow,
   output logic                    range_err,
   fmap_buffer_responder_if.slave  bus
);

   localparam logic [MEM_AW-1:0] LAST_PTR = MEM_AW'(DEPTH - 1);

   rd_state_e         state;
   logic [MEM_AW-1:0] wr_ptr;
   logic [MEM_AW-1:0] rd_mem_addr;
   logic              req_ok;
   logic              req_oor;
   logic              wr_en;
   logic              rd_issue;
   logic              mem_en;
   logic [MEM_AW-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_q;

   assign req_ok = in_range(int'(bus.rd_addr), int'(bus.rd_chan));

   if ((NPIX & (NPIX - 1)) == 0) begin : g_addr_shift
      assign rd_mem_addr = (MEM_AW'(bus.rd_chan) << PIX_AW) | MEM_AW'(bus.rd_addr[PIX_AW-1:0]);
   end else begin : g_addr_mul
      assign rd_mem_addr = MEM_AW'(bus.rd_chan) * MEM_AW'(NPIX) + MEM_AW'(bus.rd_addr);
   end

   // Writes only happen while not full and reads only while full, so one port suffices.
   assign wr_en    = bus.wr_valid && !full && !clear && !rst;
   assign rd_issue = (state == ST_IDLE) && bus.rd_addr_valid && full && req_ok && !clear && !rst;
   assign mem_en   = wr_en || rd_issue;
   assign mem_addr = wr_en ? wr_ptr : rd_mem_addr;
   assign mem_wdata = sat16(bus.wr_data);

   fmap_sram_sp #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_sram (
      .clk   (clk),
      .en    (mem_en),
      .we    (wr_en),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .q     (mem_q)
   );

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr   <= '0;
         full     <= 1'b0;
         overflow <= 1'b0;
      end else if (bus.wr_valid) begin
         if (full) begin
            overflow <= 1'b1;
         end else begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == LAST_PTR)
               full <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state             <= ST_IDLE;
         bus.rd_addr_ready <= 1'b0;
         bus.rd_data_valid <= 1'b0;
         range_err         <= 1'b0;
         req_oor           <= 1'b0;
         if (rst)
            bus.rd_data <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.rd_addr_valid && full) begin
                  bus.rd_addr_ready <= 1'b1;
                  req_oor           <= !req_ok;
                  if (!req_ok)
                     range_err <= 1'b1;
                  state <= ST_ACK;
               end
            end
            ST_ACK: begin
               bus.rd_addr_ready <= 1'b0;
               bus.rd_data       <= req_oor ? '0 : $signed(mem_q);
               bus.rd_data_valid <= 1'b1;
               state             <= ST_DATA;
            end
            ST_DATA: begin
               if (bus.rd_data_ready) begin
                  bus.rd_data_valid <= 1'b0;
                  state             <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fmap_buffer_responder.sv
// Randomized self-checking bench for fmap_buffer_responder against an array-based reference model.
module tb_fmap_buffer_responder;
   import fmap_buffer_responder_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic clear;
   logic full;
   logic overflow;
   logic range_err;

   fmap_buffer_responder_if bus ();

   fmap_buffer_responder dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .full      (full),
      .overflow  (overflow),
      .range_err (range_err),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int exp_mem [DEPTH];
   int exp_ptr;
   bit exp_full;
   bit exp_ovf;
   bit exp_rerr;
   int n_checks;
   int n_fail;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_sat(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   function automatic int ref_read(input int chan, input int addr);
      if (addr >= WIDTH * HEIGHT || chan >= CHANNELS) return 0;
      return exp_mem[chan * WIDTH * HEIGHT + addr];
   endfunction

   function automatic void model_beat(input int v);
      if (exp_full) begin
         exp_ovf = 1'b1;
      end else begin
         exp_mem[exp_ptr] = ref_sat(longint'(v));
         exp_ptr++;
         if (exp_ptr == CHANNELS * WIDTH * HEIGHT) exp_full = 1'b1;
      end
   endfunction

   function automatic void model_clear();
      exp_ptr  = 0;
      exp_full = 1'b0;
      exp_ovf  = 1'b0;
      exp_rerr = 1'b0;
   endfunction

   task automatic start_req(input int chan, input int addr);
      bus.rd_addr_valid = 1'b1;
      bus.rd_chan       = CHAN_W'(chan);
      bus.rd_addr       = ADDR_W'(addr);
      bus.rd_data_ready = 1'b0;
   endtask

   // Waits for the accept pulse, checks the data beat, holds it for bp cycles, then completes it.
   // With nxt set, a follow-up request is raised during the hold and must not be accepted yet.
   task automatic finish_req(input int chan, input int addr, input int bp,
                             input bit nxt, input int nchan, input int naddr);
      int n = 0;
      int exp;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.rd_addr_ready && n < 50);
      check("ack_latency", n, 1);
      bus.rd_addr_valid = 1'b0;
      exp = ref_read(chan, addr);
      if (addr >= WIDTH * HEIGHT || chan >= CHANNELS) exp_rerr = 1'b1;
      @(negedge clk);
      check("ack_pulse", bus.rd_addr_ready, 0);
      check("data_valid", bus.rd_data_valid, 1);
      check($sformatf("data[c%0d,a%0d]", chan, addr), bus.rd_data, exp);
      check("range_err", range_err, exp_rerr);
      if (nxt) start_req(nchan, naddr);
      for (int k = 0; k < bp; k++) begin
         @(negedge clk);
         check("hold_valid", bus.rd_data_valid, 1);
         check("hold_data", bus.rd_data, exp);
         if (nxt) check("no_ack_in_data", bus.rd_addr_ready, 0);
      end
      bus.rd_data_ready = 1'b1;
      @(negedge clk);
      check("valid_drop", bus.rd_data_valid, 0);
      if (nxt) check("no_ack_at_drop", bus.rd_addr_ready, 0);
      bus.rd_data_ready = 1'b0;
   endtask

   task automatic do_read(input int chan, input int addr, input int bp);
      start_req(chan, addr);
      finish_req(chan, addr, bp, 1'b0, 0, 0);
   endtask

   task automatic drive_beat(input int v);
      bus.wr_valid = 1'b1;
      bus.wr_data  = v;
      model_beat(v);
      @(negedge clk);
      bus.wr_valid = 1'b0;
   endtask

   // mode 0: ramp 0..DEPTH-1; mode 1: saturation corners then random words.
   task automatic fill(input int mode, input int early_at);
      bit early_ack  = 1'b0;
      bit early_full = 1'b0;
      int v;
      for (int i = 0; i < CHANNELS * WIDTH * HEIGHT; i++) begin
         if (mode == 0)      v = i;
         else if (i == 0)    v = 40000;
         else if (i == 1)    v = -40000;
         else if (i == 2)    v = 32'h0000_0100;
         else                v = int'($urandom);
         bus.wr_valid = 1'b1;
         bus.wr_data  = v;
         model_beat(v);
         if (i == early_at) start_req(3, 5);
         @(negedge clk);
         if (bus.rd_addr_ready) early_ack = 1'b1;
         if (i < CHANNELS * WIDTH * HEIGHT - 1 && full) early_full = 1'b1;
      end
      bus.wr_valid = 1'b0;
      check("no_full_before_last", early_full, 0);
      check("full_after_last", full, exp_full);
      if (early_at >= 0) check("no_ack_while_filling", early_ack, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      model_clear();
      rst   = 1'b1;
      clear = 1'b0;
      bus.wr_valid      = 1'b0;
      bus.wr_data       = '0;
      bus.rd_addr       = '0;
      bus.rd_chan       = '0;
      bus.rd_addr_valid = 1'b0;
      bus.rd_data_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("rst_full", full, 0);
      check("rst_overflow", overflow, 0);
      check("rst_range_err", range_err, 0);
      check("rst_addr_ready", bus.rd_addr_ready, 0);
      check("rst_data_valid", bus.rd_data_valid, 0);
      check("rst_data", bus.rd_data, 0);

      // Ramp fill with a request raised at beat 100; it is served only once full.
      fill(0, 100);
      finish_req(3, 5, 0, 1'b0, 0, 0);
      do_read(15, 1023, 1);

      // Backpressure for 5 cycles with a second request pending during the hold.
      start_req(7, 300);
      finish_req(7, 300, 5, 1'b1, 2, 17);
      finish_req(2, 17, 0, 1'b0, 0, 0);

      for (int i = 0; i < 15; i++)
         do_read($urandom_range(CHANNELS - 1), $urandom_range(WIDTH * HEIGHT - 1), $urandom_range(3));

      // Beat while full is dropped and flagged.
      drive_beat(12345);
      check("overflow", overflow, exp_ovf);
      check("full_after_ovf", full, 1);
      do_read(0, 0, 0);

      check("range_err_before", range_err, 0);
      do_read(0, WIDTH * HEIGHT, 2);
      do_read(4, 9, 0);

      // clear while a data beat is pending, with a same-cycle write that must be ignored.
      start_req(1, 7);
      @(negedge clk);
      bus.rd_addr_valid = 1'b0;
      @(negedge clk);
      check("pre_clear_valid", bus.rd_data_valid, 1);
      clear        = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_data  = 999;
      @(negedge clk);
      clear        = 1'b0;
      bus.wr_valid = 1'b0;
      model_clear();
      check("clear_valid", bus.rd_data_valid, 0);
      check("clear_full", full, 0);
      check("clear_overflow", overflow, 0);
      check("clear_range_err", range_err, 0);

      fill(1, -1);
      do_read(0, 0, 0);
      do_read(0, 1, 0);
      do_read(0, 2, 1);
      for (int i = 0; i < 12; i++)
         do_read($urandom_range(CHANNELS - 1), $urandom_range(WIDTH * HEIGHT - 1), $urandom_range(2));

      // Reset during a pending data beat also zeroes rd_data.
      start_req(0, 0);
      @(negedge clk);
      bus.rd_addr_valid = 1'b0;
      @(negedge clk);
      check("pre_rst_data", bus.rd_data, 32767);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      check("rst_mid_data", bus.rd_data, 0);
      check("rst_mid_valid", bus.rd_data_valid, 0);
      check("rst_mid_full", full, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
